if_id_fetch_queue: RTL and testbench

//  Decoupling queue between the fetch stage and the decode stage.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/if_id_fetch_queue.sv | 63 ++++++
 tb/tb_if_id_fetch_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and the fetch packet layout {pred_target, pred_taken, inst, pc}
package pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pred_target;
    logic            pred_taken;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;
endpackage

// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: FIFO of fetch packets between IF and ID; flush empties it on a mispredict
//   clk, rst (async active-low), flush
//   if_valid/if_ready + if_pc, if_inst, if_pred_taken, if_pred_target : push side
//   id_valid/id_ready + id_pc, id_inst, id_pred_taken, id_pred_target : pop side (NOP/zero when empty)
//   count : occupancy 0..DEPTH
module if_id_fetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_inst,
  input  logic                       if_pred_taken,
  input  logic [XLEN-1:0]            if_pred_target,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_inst,
  output logic                       id_pred_taken,
  output logic [XLEN-1:0]            id_pred_target,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  fetch_pkt_t [DEPTH-1:0] mem_q;
  fetch_pkt_t head;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic full, empty, push, pop;
  // pointers carry an extra wrap bit so full and empty are distinguishable
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = wr_ptr_q == rd_ptr_q;
  assign push  = if_valid && !full && !flush;
  assign pop   = id_ready && !empty && !flush;
  assign count = wr_ptr_q - rd_ptr_q;
  assign if_ready = !full;
  assign id_valid = !empty;
  assign head = mem_q[rd_ptr_q[AW-1:0]];
  always_comb begin
    wr_ptr_d       = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d       = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};
    id_pc          = empty ? '0 : head.pc;
    id_inst        = empty ? NOP_INST : head.inst;
    id_pred_taken  = empty ? 1'b0 : head.pred_taken;
    id_pred_target = empty ? '0 : head.pred_target;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage needs no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{if_pred_target, if_pred_taken, if_inst, if_pc};
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue: randomized and directed checks of the fetch queue against a queue-based model
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 0, flush = 0, if_valid = 0, id_ready = 0, if_pred_taken = 0;
  logic [31:0] if_pc = 0, if_inst = 0, if_pred_target = 0;
  logic if_ready, id_valid, id_pred_taken;
  logic [31:0] id_pc, id_inst, id_pred_target;
  logic [2:0] count;
  logic [96:0] mq[$];
  int n_cmp = 0, n_bad = 0;

  if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [96:0] h;
    h = mq.size() > 0 ? mq[0] : {32'h0, 1'b0, NOP, 32'h0};
    chk({tag, "_count"}, 64'(count), 64'(mq.size()));
    chk({tag, "_id_valid"}, 64'(id_valid), 64'(mq.size() > 0));
    chk({tag, "_if_ready"}, 64'(if_ready), 64'(mq.size() < DEPTH));
    chk({tag, "_pc"}, 64'(id_pc), 64'(h[31:0]));
    chk({tag, "_inst"}, 64'(id_inst), 64'(h[63:32]));
    chk({tag, "_taken"}, 64'(id_pred_taken), 64'(h[64]));
    chk({tag, "_target"}, 64'(id_pred_target), 64'(h[96:65]));
  endtask

  task automatic step(input string tag, input logic fl, input logic v, input logic r,
                      input logic [31:0] pc, input logic [31:0] in, input logic t, input logic [31:0] tg);
    bit dp, dq;
    flush = fl; if_valid = v; id_ready = r;
    if_pc = pc; if_inst = in; if_pred_taken = t; if_pred_target = tg;
    dp = !fl && v && mq.size() < DEPTH;
    dq = !fl && r && mq.size() > 0;
    @(posedge clk); #1;
    if (fl) mq.delete();
    else begin
      if (dq) void'(mq.pop_front());
      if (dp) mq.push_back({tg, t, in, pc});
    end
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [31:0] pc);
    step(tag, 0, 1, 0, pc, pc ^ 32'hA5A5_A5A5, pc[2], $urandom);
  endtask

  initial begin
    #2;
    check_all("in_reset");
    @(posedge clk); #1 rst = 1;
    check_all("post_reset");
    // mid-run async reset with count=3
    for (int i = 0; i < 3; i++) push("pre_rst", 32'h40 + 32'(4 * i));
    chk("pre_rst_count3", 64'(count), 64'd3);
    rst = 0; #2;
    mq.delete();
    chk("async_rst_count", 64'(count), 0);
    chk("async_rst_valid", 64'(id_valid), 0);
    chk("async_rst_ready", 64'(if_ready), 1);
    chk("async_rst_inst", 64'(id_inst), 64'h13);
    rst = 1;
    // fill and drain
    for (int i = 0; i < 4; i++) push("fill", 32'(4 * i));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(if_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(id_pc), 64'(4 * i));
      step("drain", 0, 0, 1, 0, 0, 0, 0);
    end
    chk("drained_valid", 64'(id_valid), 0);
    // streaming
    for (int i = 0; i < 20; i++) begin
      logic [31:0] p;
      p = 32'h1000 + 32'(4 * i);
      step("stream", 0, 1, 1, p, p ^ 32'hA5A5_A5A5, p[2], $urandom);
      chk("stream_count", 64'(count), 1);
      chk("stream_pc", 64'(id_pc), 64'(p));
    end
    step("stream_end", 0, 0, 1, 0, 0, 0, 0);
    // flush with simultaneous push
    for (int i = 0; i < 3; i++) push("pre_flush", 32'h80 + 32'(4 * i));
    step("flush", 1, 1, 0, 32'h100, 32'h1, 1, 32'h200);
    chk("flush_count", 64'(count), 0);
    chk("flush_valid", 64'(id_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step("post_flush", 0, 0, 1, 0, 0, 0, 0);
      chk("no_0x100", 64'(id_pc == 32'h100), 0);
    end
    // random push/pop across pointer wrap
    for (int i = 0; i < 60; i++) begin
      logic [31:0] p;
      p = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step("rand", 0, 1'($urandom), 1'($urandom), p, p ^ 32'hA5A5_A5A5, p[2], $urandom);
    end
    while (mq.size() > 0) step("rand_drain", 0, 0, 1, 0, 0, 0, 0);
    // full plus pop
    for (int i = 0; i < 4; i++) push("full_fill", 32'h300 + 32'(4 * i));
    step("full_pop", 0, 1, 1, 32'h400, 32'h400 ^ 32'hA5A5_A5A5, 0, 32'h5);
    chk("full_pop_count", 64'(count), 3);
    chk("full_pop_head", 64'(id_pc), 64'h304);
    step("full_retry", 0, 1, 0, 32'h400, 32'h400 ^ 32'hA5A5_A5A5, 0, 32'h5);
    chk("full_retry_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) step("final_drain", 0, 0, 1, 0, 0, 0, 0);
    chk("final_empty", 64'(id_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
